// File: rtl/health_tracker_if.sv
// health_tracker_if: groups the per-fighter health tracker request and status
// signals so one bundle connects the game logic, the tracker and the color
// mapper.
//   frame_clk   : vsync-rate frame clock, sampled in the system clock domain
//   hit, damage : hit request and its damage (0..3)
//   heal        : +1 health request
//   round_start : restore full health, return to ALIVE
//   health_count: current health 0..MAX_HEALTH
//   health_mask : thermometer of health_count, bit 0 = leftmost box
//   show_health : 0 blanks the boxes during the blink-off phase
//   invuln/dead : state flags
//   hit_ack     : one-cycle pulse after an accepted hit
// master drives the requests; slave is the tracker.
interface health_tracker_if;
  logic       frame_clk;
  logic       hit;
  logic [1:0] damage;
  logic       heal;
  logic       round_start;
  logic [2:0] health_count;
  logic [4:0] health_mask;
  logic       show_health;
  logic       invuln;
  logic       dead;
  logic       hit_ack;

  modport master (
    output frame_clk, hit, damage, heal, round_start,
    input  health_count, health_mask, show_health, invuln, dead, hit_ack
  );

  modport slave (
    input  frame_clk, hit, damage, heal, round_start,
    output health_count, health_mask, show_health, invuln, dead, hit_ack
  );
endinterface

// File: rtl/health_tracker.sv
// health_tracker: per-fighter health state machine feeding the five-box
// health display. Counts hits and heals, holds a post-hit invulnerability
// window measured in frames, and produces the box mask and blink enable.
// Ports:
//   i_clk     : system clock, all state on the rising edge
//   i_reset_n : synchronous active-low reset
//   bus       : health_tracker_if.slave (requests in, status out)
// Parameters:
//   MAX_HEALTH    : full health, 1..5
//   INVULN_FRAMES : frame ticks of invulnerability after a non-lethal hit, >=1
//   FLASH_PERIOD  : frames per half-period of the invulnerability blink, >=1
module health_tracker #(
  parameter int MAX_HEALTH    = 5,
  parameter int INVULN_FRAMES = 60,
  parameter int FLASH_PERIOD  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  health_tracker_if.slave  bus
);

  localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [2:0]    MAX_H    = 3'(MAX_HEALTH);
  localparam logic [6:0]    INV_LOAD = 7'(INVULN_FRAMES);
  localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic [2:0]    r_health,    w_health_nxt;
  logic [6:0]    r_inv_cnt,   w_inv_nxt;
  logic [FW-1:0] r_flash_cnt, w_flash_nxt;
  logic          r_show,      w_show_nxt;
  logic          r_hit_ack,   w_ack_nxt;
  logic          r_frame_d;

  logic          w_tick;
  logic [2:0]    w_dmg;
  logic [2:0]    w_sub;
  logic [2:0]    w_inc;
  logic [4:0]    w_mask;
  logic          w_invuln;
  logic          w_dead;

  // One-cycle pulse on each sampled rising edge of the frame clock.
  assign w_tick = bus.frame_clk & ~r_frame_d;
  assign w_dmg  = {1'b0, bus.damage};
  // Saturating subtract / increment on the health register.
  assign w_sub  = (r_health > w_dmg) ? (r_health - w_dmg) : 3'd0;
  assign w_inc  = (r_health < MAX_H) ? (r_health + 3'd1) : r_health;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= ST_ALIVE;
      r_health    <= MAX_H;
      r_inv_cnt   <= '0;
      r_flash_cnt <= '0;
      r_show      <= 1'b1;
      r_hit_ack   <= 1'b0;
      r_frame_d   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_health    <= w_health_nxt;
      r_inv_cnt   <= w_inv_nxt;
      r_flash_cnt <= w_flash_nxt;
      r_show      <= w_show_nxt;
      r_hit_ack   <= w_ack_nxt;
      r_frame_d   <= bus.frame_clk;
    end
  end

  // Next-state logic. round_start beats hit, hit beats heal.
  always_comb begin
    w_state_nxt  = r_state;
    w_health_nxt = r_health;
    w_inv_nxt    = r_inv_cnt;
    w_flash_nxt  = r_flash_cnt;
    w_show_nxt   = r_show;
    w_ack_nxt    = 1'b0;
    if (bus.round_start) begin
      w_state_nxt  = ST_ALIVE;
      w_health_nxt = MAX_H;
      w_inv_nxt    = '0;
      w_flash_nxt  = '0;
      w_show_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        ST_ALIVE: begin
          if (bus.hit) begin
            // Accepted even at zero damage; zero damage leaves state alone.
            w_ack_nxt    = 1'b1;
            w_health_nxt = w_sub;
            if (bus.damage != 2'd0) begin
              if (w_sub == 3'd0) begin
                w_state_nxt = ST_DEAD;
                w_show_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_INVULN;
                w_inv_nxt   = INV_LOAD;
                w_flash_nxt = '0;
                w_show_nxt  = 1'b0;   // blink opens in the off phase
              end
            end
          end else if (bus.heal) begin
            w_health_nxt = w_inc;
          end
        end
        ST_INVULN: begin
          if (bus.heal) w_health_nxt = w_inc;
          if (w_tick) begin
            if (r_inv_cnt == 7'd1) begin
              w_state_nxt = ST_ALIVE;
              w_inv_nxt   = '0;
              w_show_nxt  = 1'b1;
            end else begin
              w_inv_nxt = r_inv_cnt - 7'd1;
              if (r_flash_cnt == FL_LAST) begin
                w_flash_nxt = '0;
                w_show_nxt  = ~r_show;
              end else begin
                w_flash_nxt = r_flash_cnt + FW'(1);
              end
            end
          end
        end
        ST_DEAD: begin
          w_health_nxt = 3'd0;
          w_show_nxt   = 1'b1;
        end
        default: begin
          w_state_nxt = ST_ALIVE;
        end
      endcase
    end
  end

  // Output logic: flags from state, mask from the health register only.
  always_comb begin
    w_invuln = (r_state == ST_INVULN);
    w_dead   = (r_state == ST_DEAD);
    w_mask   = '0;
    for (int i = 0; i < 5; i++) begin
      w_mask[i] = (r_health > 3'(i)) && (i < MAX_HEALTH);
    end
  end

  assign bus.health_count = r_health;
  assign bus.health_mask  = w_mask;
  assign bus.show_health  = r_show;
  assign bus.invuln       = w_invuln;
  assign bus.dead         = w_dead;
  assign bus.hit_ack      = r_hit_ack;

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  health_tracker_if u_if ();
  health_tracker_if u_if3 ();

  health_tracker u_dut (.i_clk(clk), .i_reset_n(rst_n), .bus(u_if));
  health_tracker #(.MAX_HEALTH(3)) u_dut3 (.i_clk(clk), .i_reset_n(rst_n), .bus(u_if3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: frame_clk high for one cycle (tick at that edge), then low.
  task automatic do_frame();
    u_if.frame_clk = 1'b1;
    cyc();
    u_if.frame_clk = 1'b0;
    cyc();
  endtask

  task automatic idle();
    u_if.hit = 1'b0; u_if.heal = 1'b0; u_if.round_start = 1'b0; u_if.damage = 2'd0;
  endtask

  initial begin
    u_if.frame_clk = 1'b0;
    idle();
    u_if3.frame_clk = 1'b0; u_if3.hit = 1'b0; u_if3.damage = 2'd0;
    u_if3.heal = 1'b0; u_if3.round_start = 1'b0;

    // Reset
    cyc(); cyc();
    chk("rst_count",  u_if.health_count, 5);
    chk("rst_mask",   u_if.health_mask, 5'b11111);
    chk("rst_show",   u_if.show_health, 1);
    chk("rst_invuln", u_if.invuln, 0);
    chk("rst_dead",   u_if.dead, 0);
    chk("rst_ack",    u_if.hit_ack, 0);
    chk("rst3_count", u_if3.health_count, 3);
    chk("rst3_mask",  u_if3.health_mask, 5'b00111);
    rst_n = 1'b1;
    cyc();

    // Hit damage 1
    u_if.hit = 1'b1; u_if.damage = 2'd1;
    cyc();
    chk("hit1_count",  u_if.health_count, 4);
    chk("hit1_mask",   u_if.health_mask, 5'b01111);
    chk("hit1_invuln", u_if.invuln, 1);
    chk("hit1_show",   u_if.show_health, 0);
    chk("hit1_ack",    u_if.hit_ack, 1);
    // Held hit during INVULN is ignored
    u_if.damage = 2'd3;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_ack",   u_if.hit_ack, 0);
      chk("hold_count", u_if.health_count, 4);
    end
    idle();

    // Invulnerability window with blink
    for (int n = 1; n <= 60; n++) begin
      do_frame();
      if (n < 60) begin
        chk("win_invuln", u_if.invuln, 1);
        chk("win_show",   u_if.show_health, ((n / 8) % 2));
      end else begin
        chk("exit_invuln", u_if.invuln, 0);
        chk("exit_show",   u_if.show_health, 1);
      end
    end

    // Heal 4 -> 5, heal at max stays 5
    u_if.heal = 1'b1;
    cyc(); chk("heal_up",  u_if.health_count, 5);
    cyc(); chk("heal_max", u_if.health_count, 5);
    idle();

    // Hit 2 -> health 3 INVULN; heal in INVULN -> 4; hit d1 after window -> 3
    u_if.hit = 1'b1; u_if.damage = 2'd2;
    cyc(); idle();
    chk("hit2_count", u_if.health_count, 3);
    u_if.heal = 1'b1;
    cyc(); idle();
    chk("inv_heal", u_if.health_count, 4);
    chk("inv_heal_state", u_if.invuln, 1);
    for (int n = 0; n < 60; n++) do_frame();
    chk("win2_exit", u_if.invuln, 0);

    // Zero damage: acked, no state or health change
    u_if.hit = 1'b1; u_if.damage = 2'd0;
    cyc(); idle();
    chk("d0_ack",    u_if.hit_ack, 1);
    chk("d0_count",  u_if.health_count, 4);
    chk("d0_invuln", u_if.invuln, 0);
    cyc();
    chk("d0_ack_off", u_if.hit_ack, 0);

    // Hit and heal together: heal dropped (4 - 1 = 3, not 4)
    u_if.hit = 1'b1; u_if.damage = 2'd1; u_if.heal = 1'b1;
    cyc(); idle();
    chk("hh_count", u_if.health_count, 3);
    chk("hh_ack",   u_if.hit_ack, 1);
    // Hit on the exit edge is ignored
    for (int n = 0; n < 59; n++) do_frame();
    chk("pre_exit_invuln", u_if.invuln, 1);
    u_if.frame_clk = 1'b1; u_if.hit = 1'b1; u_if.damage = 2'd1;
    cyc();
    u_if.frame_clk = 1'b0; idle();
    chk("exit_hit_invuln", u_if.invuln, 0);
    chk("exit_hit_count",  u_if.health_count, 3);
    chk("exit_hit_ack",    u_if.hit_ack, 0);
    cyc();
    chk("exit_hit_ack2",   u_if.hit_ack, 0);

    // Get to health 2 in ALIVE: hit d1 -> 2, wait out window
    u_if.hit = 1'b1; u_if.damage = 2'd1;
    cyc(); idle();
    for (int n = 0; n < 60; n++) do_frame();
    chk("h2_count",  u_if.health_count, 2);
    chk("h2_invuln", u_if.invuln, 0);

    // Lethal hit saturates to 0
    u_if.hit = 1'b1; u_if.damage = 2'd3;
    cyc(); idle();
    chk("dead_count", u_if.health_count, 0);
    chk("dead_mask",  u_if.health_mask, 5'b00000);
    chk("dead_flag",  u_if.dead, 1);
    chk("dead_ack",   u_if.hit_ack, 1);
    chk("dead_show",  u_if.show_health, 1);
    u_if.heal = 1'b1;
    cyc(); idle();
    chk("dead_heal", u_if.health_count, 0);
    u_if.hit = 1'b1; u_if.damage = 2'd1;
    cyc(); idle();
    chk("dead_hit_ack", u_if.hit_ack, 0);
    chk("dead_sticky",  u_if.dead, 1);

    // round_start with a simultaneous hit: hit dropped
    u_if.round_start = 1'b1; u_if.hit = 1'b1; u_if.damage = 2'd3;
    cyc(); idle();
    chk("rs_count", u_if.health_count, 5);
    chk("rs_dead",  u_if.dead, 0);
    chk("rs_ack",   u_if.hit_ack, 0);
    chk("rs_mask",  u_if.health_mask, 5'b11111);

    // Reset mid-INVULN
    u_if.hit = 1'b1; u_if.damage = 2'd2;
    cyc(); idle();
    chk("pre_rst_invuln", u_if.invuln, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_count",  u_if.health_count, 5);
    chk("mid_rst_invuln", u_if.invuln, 0);
    chk("mid_rst_show",   u_if.show_health, 1);
    cyc();
    chk("post_rst_count", u_if.health_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
